// File: rtl/bypass_nf_front_multi.sv
// Steers one metadata word and the packet that follows it to one of NUM_OUT channels.
// The destination comes from a metadata flag bit or from a round-robin pointer that skips almost-full channels.
module bypass_nf_front_multi #(
    parameter int DATA_W     = 512,
    parameter int EMPTY_W    = 6,
    parameter int META_W     = 128,
    parameter int NUM_OUT    = 4,
    parameter int MODE       = 0,
    parameter int BYPASS_BIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [META_W-1:0]            in_meta_data,
    input  logic                         in_meta_valid,
    output logic                         in_meta_ready,
    input  logic [DATA_W-1:0]            in_pkt_data,
    input  logic                         in_pkt_sop,
    input  logic                         in_pkt_eop,
    input  logic [EMPTY_W-1:0]           in_pkt_empty,
    input  logic                         in_pkt_valid,
    output logic                         in_pkt_ready,
    output logic [NUM_OUT*META_W-1:0]    out_meta_data,
    output logic [NUM_OUT-1:0]           out_meta_valid,
    input  logic [NUM_OUT-1:0]           out_meta_ready,
    output logic [NUM_OUT*DATA_W-1:0]    out_pkt_data,
    output logic [NUM_OUT-1:0]           out_pkt_sop,
    output logic [NUM_OUT-1:0]           out_pkt_eop,
    output logic [NUM_OUT-1:0]           out_pkt_valid,
    output logic [NUM_OUT*EMPTY_W-1:0]   out_pkt_empty,
    input  logic [NUM_OUT-1:0]           out_pkt_ready,
    input  logic [NUM_OUT-1:0]           out_almost_full,
    output logic [NUM_OUT*CNT_W-1:0]     pkt_cnt,
    output logic [$clog2(NUM_OUT)-1:0]   cur_dest
);
    localparam int DEST_W = $clog2(NUM_OUT);
    localparam logic [DEST_W-1:0] LAST_CH = DEST_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {IDLE, META, PKT} state_t;

    state_t              state_reg, state_next;
    logic [DEST_W-1:0]   cur_dest_reg, cur_dest_next;
    logic [DEST_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic                meta_fire;
    logic                eop_fire;

    function automatic logic [DEST_W-1:0] wrap_inc(input logic [DEST_W-1:0] p);
        return (p == LAST_CH) ? '0 : p + DEST_W'(1);
    endfunction

    assign in_meta_ready = (state_reg == META) && out_meta_ready[cur_dest_reg];
    assign in_pkt_ready  = (state_reg == PKT)  && out_pkt_ready[cur_dest_reg];
    assign meta_fire     = in_meta_valid && in_meta_ready;
    assign eop_fire      = in_pkt_valid && in_pkt_ready && in_pkt_eop;
    assign cur_dest      = cur_dest_reg;

    always_comb begin
        state_next    = state_reg;
        cur_dest_next = cur_dest_reg;
        rr_ptr_next   = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (in_meta_valid) begin
                    if (MODE == 0) begin
                        cur_dest_next = in_meta_data[BYPASS_BIT] ? LAST_CH : '0;
                        state_next    = META;
                    end else if (!out_almost_full[rr_ptr_reg]) begin
                        cur_dest_next = rr_ptr_reg;
                        state_next    = META;
                    end else begin
                        // Probe only one channel per cycle so the skip is visible and bounded.
                        rr_ptr_next = wrap_inc(rr_ptr_reg);
                    end
                end
            end
            META: begin
                if (meta_fire) begin
                    state_next = PKT;
                end
            end
            PKT: begin
                if (eop_fire) begin
                    state_next = IDLE;
                    if (MODE != 0) begin
                        rr_ptr_next = wrap_inc(cur_dest_reg);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cur_dest_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cur_dest_reg <= cur_dest_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    // Data and empty fan out to every channel; only the selected channel sees valid/framing.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_ch
            logic             sel;
            logic [CNT_W-1:0] cnt_reg;

            assign sel = (cur_dest_reg == DEST_W'(gi));

            assign out_meta_data[gi*META_W +: META_W]   = in_meta_data;
            assign out_meta_valid[gi]                   = (state_reg == META) && sel && in_meta_valid;
            assign out_pkt_data[gi*DATA_W +: DATA_W]    = in_pkt_data;
            assign out_pkt_empty[gi*EMPTY_W +: EMPTY_W] = in_pkt_empty;
            assign out_pkt_valid[gi]                    = (state_reg == PKT) && sel && in_pkt_valid;
            assign out_pkt_sop[gi]                      = (state_reg == PKT) && sel && in_pkt_sop;
            assign out_pkt_eop[gi]                      = (state_reg == PKT) && sel && in_pkt_eop;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (eop_fire && sel) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

endmodule
